// File: rtl/morph_pkg.sv
// Shared types and constants for the binary morphology filter.
package morph_pkg;

  typedef enum logic {
    MODE_ERODE  = 1'b0,
    MODE_DILATE = 1'b1
  } morph_mode_e;

  localparam int LAT = 3;

  function automatic int halfk(input int ksize);
    return (ksize - 1) / 2;
  endfunction

endpackage

// File: rtl/morph_line_buf.sv
// Cascaded 1-bit line buffers sharing one address; bit i of a word holds the
// sample from i+1 lines above the current one.
module morph_line_buf #(
  parameter int DEPTH  = 640,
  parameter int NLINES = 2,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic              din_i,
  output logic [NLINES-1:0] taps_o
);

  logic [NLINES-1:0] mem [DEPTH];

  // Asynchronous read returns the old word, so the write below is read-before-write.
  assign taps_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= {mem[addr_i][NLINES-2:0], din_i};
    end
  end

endmodule

// File: rtl/morph_bin_filter.sv
// Binary erode/dilate filter with a KSIZE x KSIZE square kernel, 3-cycle latency,
// neutral border masking and line-overflow detection.
module morph_bin_filter
  import morph_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int KSIZE  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              vsync_i,
  input  logic              hsync_i,
  input  logic              data_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic              data_en_o,
  output logic [DATA_W-1:0] data_o,
  output logic              line_err_o
);

  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = 12;
  localparam int NL    = KSIZE - 1;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("morph_bin_filter: KSIZE must be 3 or 5");
  end

  // data_en_i is a valid-only strobe: there is no backpressure, every beat is consumed.
  logic                        vs_prev_q, vs_prev_d, en_prev_q, en_prev_d;
  morph_mode_e                 mode_q, mode_d;
  logic [AW-1:0]               col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic                        full_q, full_d, err_seen_q, err_seen_d;
  logic                        line_err_q, line_err_d;
  logic [KSIZE-1:0][KSIZE-1:0] win_q, win_d;
  logic [AW-1:0]               col1_q, col1_d;
  logic [ROW_W-1:0]            row1_q, row1_d;
  morph_mode_e                 mode1_q, mode1_d, mode2_q, mode2_d;
  logic [KSIZE-1:0]            rowred_q, rowred_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [LAT-1:0]              vs_dly_q, vs_dly_d, hs_dly_q, hs_dly_d, en_dly_q, en_dly_d;

  logic             vs_rise, en_fall, beat_wr, pix, red, tap_bit;
  morph_mode_e      cur_mode;
  logic [ROW_W-1:0] cur_row;
  logic [NL-1:0]    taps;
  logic [KSIZE-1:0] new_col;

  morph_line_buf #(
    .DEPTH  (IMG_W),
    .NLINES (NL),
    .AW     (AW)
  ) u_line_buf (
    .clk    (clk),
    .addr_i (col_q),
    .we_i   (beat_wr),
    .din_i  (pix),
    .taps_o (taps)
  );

  always_comb begin
    red      = 1'b0;
    tap_bit  = 1'b0;
    vs_rise  = vsync_i & ~vs_prev_q;
    en_fall  = ~data_en_i & en_prev_q;
    pix      = |data_i;
    beat_wr  = data_en_i & ~full_q;
    cur_mode = vs_rise ? morph_mode_e'(mode_i) : mode_q;
    cur_row  = vs_rise ? '0 : row_q;
    new_col  = {taps, pix};

    vs_prev_d = vsync_i;
    en_prev_d = data_en_i;
    mode_d    = cur_mode;

    row_d = cur_row;
    if (en_fall && !vs_rise && row_q != '1) row_d = row_q + ROW_W'(1);

    // Column saturates at IMG_W-1; full_q marks every later beat as excess.
    col_d      = col_q;
    full_d     = full_q;
    err_seen_d = err_seen_q;
    line_err_d = data_en_i & full_q & ~err_seen_q;
    if (en_fall) begin
      col_d      = '0;
      full_d     = 1'b0;
      err_seen_d = 1'b0;
    end else if (data_en_i) begin
      if (full_q)                       err_seen_d = 1'b1;
      else if (col_q == AW'(IMG_W - 1)) full_d     = 1'b1;
      else                              col_d      = col_q + AW'(1);
    end

    // Stage 1: win[r][c] is the sample r lines up and c columns left.
    win_d = win_q;
    if (data_en_i) begin
      for (int r = 0; r < KSIZE; r++) win_d[r] = {win_q[r][KSIZE-2:0], new_col[r]};
    end
    col1_d  = col_q;
    row1_d  = cur_row;
    mode1_d = cur_mode;

    // Stage 2: taps outside the image read as the neutral value of the operation.
    rowred_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      red = (mode1_q == MODE_ERODE);
      for (int c = 0; c < KSIZE; c++) begin
        tap_bit = (32'(col1_q) >= c && 32'(row1_q) >= r) ? win_q[r][c]
                                                          : (mode1_q == MODE_ERODE);
        red = (mode1_q == MODE_DILATE) ? (red | tap_bit) : (red & tap_bit);
      end
      rowred_d[r] = red;
    end
    mode2_d = mode1_q;

    // Stage 3
    data_d = '0;
    if (en_dly_q[1] && ((mode2_q == MODE_DILATE) ? |rowred_q : &rowred_q)) data_d = '1;

    vs_dly_d = {vs_dly_q[LAT-2:0], vsync_i};
    hs_dly_d = {hs_dly_q[LAT-2:0], hsync_i};
    en_dly_d = {en_dly_q[LAT-2:0], data_en_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev_q  <= 1'b0;
      en_prev_q  <= 1'b0;
      mode_q     <= MODE_ERODE;
      col_q      <= '0;
      row_q      <= '0;
      full_q     <= 1'b0;
      err_seen_q <= 1'b0;
      line_err_q <= 1'b0;
      win_q      <= '0;
      col1_q     <= '0;
      row1_q     <= '0;
      mode1_q    <= MODE_ERODE;
      mode2_q    <= MODE_ERODE;
      rowred_q   <= '0;
      data_q     <= '0;
      vs_dly_q   <= '0;
      hs_dly_q   <= '0;
      en_dly_q   <= '0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      en_prev_q  <= en_prev_d;
      mode_q     <= mode_d;
      col_q      <= col_d;
      row_q      <= row_d;
      full_q     <= full_d;
      err_seen_q <= err_seen_d;
      line_err_q <= line_err_d;
      win_q      <= win_d;
      col1_q     <= col1_d;
      row1_q     <= row1_d;
      mode1_q    <= mode1_d;
      mode2_q    <= mode2_d;
      rowred_q   <= rowred_d;
      data_q     <= data_d;
      vs_dly_q   <= vs_dly_d;
      hs_dly_q   <= hs_dly_d;
      en_dly_q   <= en_dly_d;
    end
  end

  assign vsync_o    = vs_dly_q[LAT-1];
  assign hsync_o    = hs_dly_q[LAT-1];
  assign data_en_o  = en_dly_q[LAT-1];
  assign data_o     = data_q;
  assign line_err_o = line_err_q;

endmodule
